// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the pipelined multiply-accumulate engine:
//   - default parameter values for mac_pipe and mac_acc_stage
//   - sat_add(): signed add with overflow detect and optional saturation,
//     evaluated at a run-time width inside a fixed 64-bit container
//   - acc_w_ok(): elaboration-time legality check for the width parameters
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int IN_W_DEF  = 8;
    localparam int ACC_W_DEF = 26;
    localparam int LEN_W_DEF = 10;
    localparam int SAT_DEF   = 1;

    // Container width for sat_add; accumulator widths must stay strictly below it
    // so that sign-extension into the container always has at least one bit.
    localparam int SA_W = 64;

    typedef struct packed {
        logic            ovf;
        logic [SA_W-1:0] sum;
    } sat_res_t;

    // a and b are w-bit signed values sign-extended to SA_W bits. The returned
    // sum is meaningful in its low w bits; the caller truncates.
    function automatic sat_res_t sat_add(
        input logic [SA_W-1:0] a,
        input logic [SA_W-1:0] b,
        input int              w,
        input logic            sat_en
    );
        logic [SA_W-1:0] raw;
        logic [SA_W-1:0] msb;
        logic [SA_W-1:0] max_v;
        logic            sa;
        logic            sb;
        logic            sr;
        sat_res_t        r;
        raw   = a + b;
        msb   = 64'd1 << (w - 1);
        max_v = msb - 64'd1;
        sa    = (a & msb) != 64'd0;
        sb    = (b & msb) != 64'd0;
        sr    = (raw & msb) != 64'd0;
        r.ovf = (sa == sb) && (sr != sa);
        if (r.ovf && sat_en) begin
            // ~max_v is -2^(w-1) sign-extended to the container
            r.sum = sa ? ~max_v : max_v;
        end else begin
            r.sum = raw;
        end
        return r;
    endfunction

    // Product must fit the accumulator, and the accumulator must fit sat_add.
    function automatic logic acc_w_ok(input int in_w, input int acc_w);
        return (acc_w >= 2 * in_w) && (acc_w < SA_W);
    endfunction

endpackage

// File: rtl/mac_acc_stage.sv
// -----------------------------------------------------------------------------
// mac_acc_stage
// Stage 2 of mac_pipe: accumulates stage-1 products, saturates or wraps on
// overflow and keeps a per-vector sticky overflow flag.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous flush of accumulator and sticky flag
//   vld, last   : stage-1 product valid / product is the vector's last
//   hold        : stage 1 is stalled; accumulator must not update
//   prod        : signed stage-1 product (2*IN_W bits)
//   fin         : last product is being absorbed this cycle (load result)
//   sum, ovf    : this-cycle sum and vector overflow (sticky | this overflow)
// -----------------------------------------------------------------------------
module mac_acc_stage
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int SAT   = SAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              vld,
    input  logic              last,
    input  logic              hold,
    input  logic [2*IN_W-1:0] prod,
    output logic              fin,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] acc_r;
    logic             sticky_r;
    logic [SA_W-1:0]  acc_ext_s;
    logic [SA_W-1:0]  prod_ext_s;
    sat_res_t         add_s;
    logic             upd_s;
    logic             unused_hi_s;

    // Sign-extend both operands into the adder container and add.
    always_comb begin
        acc_ext_s  = {{(SA_W - ACC_W){acc_r[ACC_W-1]}}, acc_r};
        prod_ext_s = {{(SA_W - 2 * IN_W){prod[2*IN_W-1]}}, prod};
        add_s      = sat_add(acc_ext_s, prod_ext_s, ACC_W, (SAT != 32'sd0));
    end

    // clr wins over the accumulate step.
    assign upd_s       = vld && !hold && !clr;
    assign fin         = upd_s && last;
    assign sum         = add_s.sum[ACC_W-1:0];
    assign ovf         = sticky_r | add_s.ovf;
    assign unused_hi_s = ^add_s.sum[SA_W-1:ACC_W];

    // Accumulator and sticky flag; the last product restarts both at zero so the
    // next vector can follow without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {ACC_W{1'b0}};
            sticky_r <= 1'b0;
        end else if (clr) begin
            acc_r    <= {ACC_W{1'b0}};
            sticky_r <= 1'b0;
        end else if (upd_s) begin
            if (last) begin
                acc_r    <= {ACC_W{1'b0}};
                sticky_r <= 1'b0;
            end else begin
                acc_r    <= sum;
                sticky_r <= ovf;
            end
        end
    end

endmodule

// File: rtl/mac_pipe.sv
// -----------------------------------------------------------------------------
// mac_pipe
// Pipelined signed multiply-accumulate over vectors of operand pairs.
// Stage 1 multiplies, stage 2 (mac_acc_stage) accumulates; one result per
// vector is presented on a registered valid/ready output.
//   clk, rst_n       : clock, asynchronous active-low reset
//   clr              : synchronous flush of partial vector and stage 1
//   in_vld/in_rdy    : operand handshake; in1, in2 signed IN_W operands
//   vec_len          : products per vector, sampled with the first element
//                      (0 is treated as 1)
//   res_vld/res_rdy  : result handshake; res signed ACC_W, res_ovf overflow
//   busy             : partial vector in progress or stage 1 occupied
// -----------------------------------------------------------------------------
module mac_pipe
    import mac_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int SAT   = SAT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [IN_W-1:0]  in1,
    input  logic [IN_W-1:0]  in2,
    input  logic [LEN_W-1:0] vec_len,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [ACC_W-1:0] res,
    output logic             res_ovf,
    output logic             busy
);

    if (!acc_w_ok(IN_W, ACC_W)) begin : g_bad_acc_w
        $error("mac_pipe: ACC_W must be >= 2*IN_W and < 64");
    end

    logic                     alive_r;
    logic                     s1_vld_r;
    logic                     s1_last_r;
    logic signed [2*IN_W-1:0] prod_r;
    logic [LEN_W-1:0]         cnt_r;
    logic [LEN_W-1:0]         len_m1_r;
    logic [ACC_W-1:0]         res_r;
    logic                     res_vld_r;
    logic                     res_ovf_r;

    logic                     stall_s;
    logic                     accept_s;
    logic [LEN_W-1:0]         len_first_s;
    logic [LEN_W-1:0]         len_cur_s;
    logic                     last_s;
    logic signed [2*IN_W-1:0] in1_ext_s;
    logic signed [2*IN_W-1:0] in2_ext_s;
    logic                     fin_s;
    logic [ACC_W-1:0]         sum_s;
    logic                     ovf_s;

    // Only a last product blocked by an unconsumed result can stall; partial
    // products never reach the output register.
    assign stall_s  = s1_vld_r && s1_last_r && res_vld_r && !res_rdy;
    assign in_rdy   = alive_r && !stall_s && !clr;
    assign accept_s = in_vld && in_rdy;
    assign busy     = s1_vld_r || (cnt_r != {LEN_W{1'b0}});

    // Length of the current vector; on its first element the fresh vec_len is used
    // directly since len_m1_r is only written on that same edge.
    always_comb begin
        if (vec_len == {LEN_W{1'b0}}) begin
            len_first_s = {LEN_W{1'b0}};
        end else begin
            len_first_s = vec_len - LEN_W'(1'b1);
        end
        if (cnt_r == {LEN_W{1'b0}}) begin
            len_cur_s = len_first_s;
        end else begin
            len_cur_s = len_m1_r;
        end
        last_s    = (cnt_r == len_cur_s);
        in1_ext_s = {{IN_W{in1[IN_W-1]}}, in1};
        in2_ext_s = {{IN_W{in2[IN_W-1]}}, in2};
    end

    // Holds in_rdy low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Stage 1: registered product and its last-element tag; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
            prod_r    <= {(2 * IN_W){1'b0}};
        end else if (clr) begin
            s1_vld_r  <= 1'b0;
            s1_last_r <= 1'b0;
        end else if (!stall_s) begin
            s1_vld_r <= accept_s;
            if (accept_s) begin
                s1_last_r <= last_s;
                prod_r    <= in1_ext_s * in2_ext_s;
            end
        end
    end

    // Element counter and latched vector length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {LEN_W{1'b0}};
            len_m1_r <= {LEN_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            if (cnt_r == {LEN_W{1'b0}}) begin
                len_m1_r <= len_first_s;
            end
            if (last_s) begin
                cnt_r <= {LEN_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + LEN_W'(1'b1);
            end
        end
    end

    mac_acc_stage #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .vld   (s1_vld_r),
        .last  (s1_last_r),
        .hold  (stall_s),
        .prod  (prod_r),
        .fin   (fin_s),
        .sum   (sum_s),
        .ovf   (ovf_s)
    );

    // Result register: a new load wins over a same-cycle handshake; clr leaves
    // a pending result alone so it still drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r     <= {ACC_W{1'b0}};
            res_ovf_r <= 1'b0;
            res_vld_r <= 1'b0;
        end else if (fin_s) begin
            res_r     <= sum_s;
            res_ovf_r <= ovf_s;
            res_vld_r <= 1'b1;
        end else if (res_rdy) begin
            res_vld_r <= 1'b0;
        end
    end

    assign res     = res_r;
    assign res_ovf = res_ovf_r;
    assign res_vld = res_vld_r;

endmodule

// File: tb/tb_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_mac_pipe
// Three mac_pipe instances share one stimulus stream: defaults (26-bit,
// saturating), 16-bit saturating and 16-bit wrapping. A reference model built
// from integer arithmetic predicts each instance's result stream.
// -----------------------------------------------------------------------------
module tb_mac_pipe;

    localparam int IN_W  = 8;
    localparam int LEN_W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             clr;
    logic             in_vld;
    logic             res_rdy;
    logic [IN_W-1:0]  in1;
    logic [IN_W-1:0]  in2;
    logic [LEN_W-1:0] vec_len;

    logic        in_rdy_a, res_vld_a, res_ovf_a, busy_a;
    logic        in_rdy_b, res_vld_b, res_ovf_b, busy_b;
    logic        in_rdy_c, res_vld_c, res_ovf_c, busy_c;
    logic [25:0] res_a;
    logic [15:0] res_b;
    logic [15:0] res_c;

    mac_pipe u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy_a),
        .in1(in1), .in2(in2), .vec_len(vec_len), .res_vld(res_vld_a),
        .res_rdy(res_rdy), .res(res_a), .res_ovf(res_ovf_a), .busy(busy_a)
    );

    mac_pipe #(.ACC_W(16), .SAT(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy_b),
        .in1(in1), .in2(in2), .vec_len(vec_len), .res_vld(res_vld_b),
        .res_rdy(res_rdy), .res(res_b), .res_ovf(res_ovf_b), .busy(busy_b)
    );

    mac_pipe #(.ACC_W(16), .SAT(0)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy_c),
        .in1(in1), .in2(in2), .vec_len(vec_len), .res_vld(res_vld_c),
        .res_rdy(res_rdy), .res(res_c), .res_ovf(res_ovf_c), .busy(busy_c)
    );

    logic   rdy_v[3];
    logic   vld_v[3];
    logic   ovf_v[3];
    longint res_v[3];

    always_comb begin
        rdy_v[0] = in_rdy_a;  rdy_v[1] = in_rdy_b;  rdy_v[2] = in_rdy_c;
        vld_v[0] = res_vld_a; vld_v[1] = res_vld_b; vld_v[2] = res_vld_c;
        ovf_v[0] = res_ovf_a; ovf_v[1] = res_ovf_b; ovf_v[2] = res_ovf_c;
        res_v[0] = longint'($signed(res_a));
        res_v[1] = longint'($signed(res_b));
        res_v[2] = longint'($signed(res_c));
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic signed [63:0] r;
        logic               o;
    } exp_t;

    exp_t   exp_q[3][$];
    int     m_cnt[3];
    int     m_len[3];
    longint m_acc[3];
    bit     m_ovf[3];

    function automatic int inst_w(input int i);
        return (i == 0) ? 26 : 16;
    endfunction

    function automatic bit inst_sat(input int i);
        return (i != 2);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endfunction

    function automatic void model_accept(input int i, input longint p, input int vlen);
        longint hi;
        longint lo;
        longint s;
        exp_t   e;
        hi = (longint'(1) <<< (inst_w(i) - 1)) - 1;
        lo = -hi - 1;
        if (m_cnt[i] == 0) m_len[i] = (vlen == 0) ? 1 : vlen;
        s = m_acc[i] + p;
        if (s > hi || s < lo) begin
            m_ovf[i] = 1'b1;
            if (inst_sat(i)) s = (s > hi) ? hi : lo;
            else if (s > hi) s = s - 2 * (hi + 1);
            else s = s + 2 * (hi + 1);
        end
        m_acc[i] = s;
        m_cnt[i]++;
        if (m_cnt[i] == m_len[i]) begin
            e.r = s;
            e.o = m_ovf[i];
            exp_q[i].push_back(e);
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endfunction

    // Monitor: inputs are stable at the falling edge, so a handshake seen here
    // takes effect at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (vld_v[i] && res_rdy) begin
                    if (exp_q[i].size() == 0) begin
                        chk_eq($sformatf("res_unexpected%0d", i), longint'(vld_v[i]), 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        chk_eq($sformatf("res%0d", i), res_v[i], e.r);
                        chk_eq($sformatf("ovf%0d", i), longint'(ovf_v[i]), longint'(e.o));
                    end
                end
            end
            if (clr) begin
                model_clear();
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (in_vld && rdy_v[i]) begin
                        model_accept(i, longint'($signed(in1)) * longint'($signed(in2)),
                                     int'(vec_len));
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    bit     rnd_rdy = 1'b0;
    longint cap_res[3];
    longint cap_ovf[3];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) res_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input int l,
                        output int tries);
        bit ok;
        ok = 1'b0;
        tries = 0;
        in1 = a;
        in2 = b;
        vec_len = LEN_W'(l);
        in_vld = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = rdy_v[0];
            tries = k + 1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_vld = 1'b0;
        if (!ok) chk_eq("send_timeout", longint'(ok), 1);
    endtask

    // Waits for res_vld on the default instance, captures all three outputs and
    // returns aligned just after the next rising edge.
    task automatic wait_res(output int lat);
        bit found;
        found = 1'b0;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (vld_v[0]) begin
                found = 1'b1;
                lat = k;
                for (int i = 0; i < 3; i++) begin
                    cap_res[i] = res_v[i];
                    cap_ovf[i] = longint'(ovf_v[i]);
                end
                break;
            end
        end
        if (!found) chk_eq("wait_res_timeout", longint'(found), 1);
        step();
    endtask

    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 3))
            0:       return 8'h7f;
            1:       return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int t;
        int lat;
        int l;
        rst_n = 1'b0; clr = 1'b0; in_vld = 1'b0; res_rdy = 1'b1;
        in1 = '0; in2 = '0; vec_len = '0;
        model_clear();

        // reset state
        #12;
        chk_eq("rst_res_vld", longint'(res_vld_a), 0);
        chk_eq("rst_res", res_v[0], 0);
        chk_eq("rst_res_ovf", longint'(res_ovf_a), 0);
        chk_eq("rst_busy", longint'(busy_a), 0);
        chk_eq("rst_in_rdy", longint'(in_rdy_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_eq("in_rdy_after_rst", longint'(in_rdy_a), 1);

        // T1: basic vector, back-to-back, latency 2
        send(8'd3, 8'd4, 4, t);     chk_eq("t1_rdy0", t, 1);
        send(-8'sd5, 8'd6, 4, t);   chk_eq("t1_rdy1", t, 1);
        chk_eq("t1_busy_mid", longint'(busy_a), 1);
        send(8'd127, 8'd127, 4, t); chk_eq("t1_rdy2", t, 1);
        send(8'h80, 8'h80, 4, t);   chk_eq("t1_rdy3", t, 1);
        wait_res(lat);
        chk_eq("t1_latency", lat, 2);
        chk_eq("t1_res", cap_res[0], 32495);
        chk_eq("t1_ovf", cap_ovf[0], 0);

        // T2: overflow, saturate vs wrap, then clean next vector
        for (int k = 0; k < 3; k++) send(8'd127, 8'd127, 3, t);
        wait_res(lat);
        chk_eq("t2_res_w26", cap_res[0], 48387);
        chk_eq("t2_ovf_w26", cap_ovf[0], 0);
        chk_eq("t2_res_sat", cap_res[1], 32767);
        chk_eq("t2_ovf_sat", cap_ovf[1], 1);
        chk_eq("t2_res_wrap", cap_res[2], -17149);
        chk_eq("t2_ovf_wrap", cap_ovf[2], 1);
        send(8'd1, 8'd1, 1, t);
        wait_res(lat);
        chk_eq("t2b_res_sat", cap_res[1], 1);
        chk_eq("t2b_ovf_sat", cap_ovf[1], 0);
        chk_eq("t2b_res_wrap", cap_res[2], 1);
        chk_eq("t2b_ovf_wrap", cap_ovf[2], 0);

        // T3: backpressure on last products
        res_rdy = 1'b0;
        send(8'd2, 8'd3, 1, t);
        send(8'd4, 8'd5, 1, t);
        chk_eq("t3_accept45", t, 1);
        in1 = 8'd6; in2 = 8'd7; vec_len = 10'd1; in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_eq("t3_stall_rdy", longint'(in_rdy_a), 0);
            chk_eq("t3_hold_vld", longint'(res_vld_a), 1);
            chk_eq("t3_hold_res", res_v[0], 6);
            step();
        end
        res_rdy = 1'b1;
        send(8'd6, 8'd7, 1, t);
        repeat (4) step();

        // T4: vec_len 0 acts as 1
        send(-8'sd7, 8'd9, 0, t);
        wait_res(lat);
        chk_eq("t4_res", cap_res[0], -63);

        // T5: clr mid-vector
        send(8'd10, 8'd10, 4, t);
        send(8'd10, 8'd10, 4, t);
        clr = 1'b1;
        step();
        clr = 1'b0;
        send(8'd1, 8'd2, 2, t);
        send(8'd3, 8'd4, 2, t);
        wait_res(lat);
        chk_eq("t5_res", cap_res[0], 14);
        repeat (2) step();
        chk_eq("t5_busy", longint'(busy_a), 0);

        // T6: result pending across clr is preserved
        res_rdy = 1'b0;
        send(8'd9, 8'd9, 1, t);
        wait_res(lat);
        send(8'd1, 8'd1, 3, t);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_eq("t6_pend_vld", longint'(res_vld_a), 1);
        chk_eq("t6_pend_res", res_v[0], 81);
        chk_eq("t6_busy", longint'(busy_a), 0);
        res_rdy = 1'b1;
        repeat (2) step();
        chk_eq("t6_drained", longint'(res_vld_a), 0);

        // Random phase
        rnd_rdy = 1'b1;
        for (int v = 0; v < 60; v++) begin
            l = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 6);
            for (int e = 0; e < ((l == 0) ? 1 : l); e++) begin
                repeat ($urandom_range(0, 2)) step();
                send(rnd_op(), rnd_op(), l, t);
            end
        end
        rnd_rdy = 1'b0;
        step();
        res_rdy = 1'b1;
        repeat (10) step();

        // T7: reset mid-vector
        send(8'd1, 8'd1, 5, t);
        send(8'd1, 8'd1, 5, t);
        rst_n = 1'b0;
        #1;
        chk_eq("t7_rst_vld", longint'(res_vld_a), 0);
        chk_eq("t7_rst_busy", longint'(busy_a), 0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(8'd5, 8'd5, 2, t);
        send(8'd5, 8'd5, 2, t);
        wait_res(lat);
        chk_eq("t7_res", cap_res[0], 50);
        repeat (4) step();

        for (int i = 0; i < 3; i++) begin
            chk_eq($sformatf("drain%0d", i), exp_q[i].size(), 0);
        end
        chk_eq("end_busy", longint'(busy_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
